lsu_64i: RTL and testbench
==========================

# lsu_64i

Load/store unit for the RV64I core. It sits in the execute stage and consumes the 7-bit `lsu_op` bundle produced by the instruction decoder, together with the computed address and store data. It drives a single-outstanding data-memory bus, generates byte strobes and lane-shifted store data, and returns aligned, sign- or zero-extended load results for writeback. Every access is a multi-cycle transaction sequenced by a small FSM.

## Interface
- `ADDR_WIDTH`, default 64: width of the address datapath. The data path is fixed at 64 bits.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: execute stage presents an op.
- `req_ready` out 1: high only in IDLE.
- `lsu_op` in 7: op bundle.
  - [6] en; [5] we.
  - [4:1] size one-hot: [1] byte, [2] half, [3] word, [4] double.
  - [0] unsigned.
- `addr` in ADDR_WIDTH: effective address (rs1 + imm).
- `wdata` in 64: store data (rs2).
- `mem_req_valid` out 1: bus request.
- `mem_req_ready` in 1: bus accepts the request.
- `mem_addr` out ADDR_WIDTH: address with bits [2:0] forced to 0.
- `mem_we` out 1: write request.
- `mem_wstrb` out 8: byte enables.
- `mem_wdata` out 64: lane-shifted store data.
- `mem_resp_valid` in 1: read data or write acknowledge.
- `mem_rdata` in 64: read data.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 64: extended load result; 0 for stores.
- `resp_misalign` out 1: address fault, valid with `resp_valid`.

## Operation
- States: IDLE, REQ, WAIT, DONE. Encoding is binary.
- IDLE:
  - When `req_valid` is high, latch `lsu_op`, `addr` and `wdata`.
  - en=0: go to DONE with data 0 and no fault.
  - Fault, meaning the size field is not one-hot, or the offset `addr[2:0]` is not a multiple of the size: go to DONE with `resp_misalign`=1. No bus access is made.
  - Otherwise go to REQ.
- REQ:
  - `mem_req_valid`=1.
  - The registered `mem_addr`, `mem_we`, `mem_wstrb` and `mem_wdata` hold stable until `mem_req_ready`.
  - On handshake, go to WAIT.
- WAIT:
  - On `mem_resp_valid`, register the extracted load data (0 for stores) and go to DONE.
- DONE:
  - `resp_valid`=1 for exactly one cycle, then go to IDLE.
- Store strobes, with offset o = `addr[2:0]`:
  - byte: 0x01<<o; half: 0x03<<o; word: 0x0F<<o; double: 0xFF.
  - `mem_wdata` = `wdata` << (8·o).
- Load extract: `mem_rdata` >> (8·o), truncate to the access size, then sign-extend, or zero-extend when unsigned=1. The unsigned bit is ignored for double.
- `mem_resp_valid` outside WAIT is discarded.

## Timing
- Reset values: state IDLE; `req_ready`=1. `mem_req_valid`, `mem_we`, `mem_wstrb`, `mem_addr`, `mem_wdata`, `resp_valid`, `resp_data` and `resp_misalign` are all 0.
- Fault or en=0: accept in cycle 0, `resp_valid` in cycle 1.
- Bus access:
  - Accept in cycle 0; `mem_req_valid` in cycle 1.
  - Earliest `mem_resp_valid` is cycle 2, one cycle after the handshake.
  - `resp_valid` follows in cycle 3.
  - Each stall cycle on `mem_req_ready` or `mem_resp_valid` adds one cycle.
- `rst` in any state forces IDLE on the next edge and drops `mem_req_valid`. A late response for the abandoned transaction is ignored, and no `resp_valid` is produced for it.
- A new op may be accepted in the cycle after DONE (back-to-back period ≥ 4 cycles).

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned offset is a fault: `resp_misalign`=1 and no bus access.
- Not defined:
  - Offset bits below the access size are cleared (the address is rounded down to natural alignment) and the access proceeds normally.
  - `resp_misalign` is asserted only for a non-one-hot size field.

## Structure
- Shared package/header:
  - `lsu_op` bit-position constants (EN, WE, SIZE_B/H/W/D, UNS).
  - FSM state encodings.
  - Strobe base constants.
- One sub-module, `lsu_load_ext`: combinational shift, truncation and sign/zero extension of `mem_rdata` given offset, size and unsigned. The store strobe/shift logic stays inline.

## Test plan
- sb with `addr`=0x1003, `wdata`=0xAB:
  - `mem_addr`=0x1000, `mem_wstrb`=0x08, `mem_wdata`=0x00000000AB000000, `mem_we`=1.
  - `resp_data`=0.
- lb / lbu with `addr`=0x2005, `mem_rdata`=0x0000800000000000:
  - lb: `resp_data`=0xFFFFFFFFFFFFFF80.
  - lbu: `resp_data`=0x0000000000000080.
- lw / lwu with `addr`=0x3004, `mem_rdata`=0x8765432100000000:
  - lw: 0xFFFFFFFF87654321.
  - lwu: 0x0000000087654321.
- ld with `addr`=0x4004 and the macro defined:
  - `resp_valid` and `resp_misalign`=1 in cycle 1; `mem_req_valid` never rises.
  - Without the macro: `mem_addr`=0x4000, `mem_wstrb` irrelevant (load), normal response.
- `mem_req_ready` held low for 3 cycles during a store:
  - Bus outputs stay stable throughout.
  - `resp_valid` arrives in cycle 6 with zero-wait response.
- `rst` pulsed while in WAIT:
  - Next cycle: IDLE, `req_ready`=1, `mem_req_valid`=0.
  - A following `mem_resp_valid` produces no `resp_valid`.

Source files
------------

// File: rtl/lsu_64i_pkg.sv
// Shared constants for the RV64I load/store unit: op-bundle bit positions,
// FSM states and byte-strobe bases.
package lsu_64i_pkg;

    localparam int OP_EN     = 6;
    localparam int OP_WE     = 5;
    localparam int OP_SIZE_D = 4;
    localparam int OP_SIZE_W = 3;
    localparam int OP_SIZE_H = 2;
    localparam int OP_SIZE_B = 1;
    localparam int OP_UNS    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/lsu_64i_load_ext.sv
// Load data alignment: shift the bus word down to the access offset, then
// truncate and sign/zero extend. Size is one-hot {d,w,h,b}.
module lsu_load_ext (
    input  logic [63:0] rdata,
    input  logic [2:0]  off,
    input  logic [3:0]  size,
    input  logic        uns,
    output logic [63:0] data
);
    logic [63:0] sh;

    assign sh = rdata >> {off, 3'b000};

    always_comb begin
        data = sh;
        if (size[0])
            data = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
        else if (size[1])
            data = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
        else if (size[2])
            data = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
    end

endmodule

// File: rtl/lsu_64i.sv
// RV64I load/store unit: single-outstanding bus, FSM IDLE->REQ->WAIT->DONE.
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned offsets instead of rounding down.
module lsu_64i
    import lsu_64i_pkg::*;
#(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [6:0]            lsu_op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [63:0]           wdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [7:0]            mem_wstrb,
    output logic [63:0]           mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic [63:0]           mem_rdata,
    output logic                  resp_valid,
    output logic [63:0]           resp_data,
    output logic                  resp_misalign
);
    state_e      state;
    logic [2:0]  off_q;
    logic [3:0]  size_q;
    logic        uns_q;

    logic [3:0]  size;
    logic        size_ok;
    logic [2:0]  amask;
    logic        fault;
    logic [2:0]  off_al;
    logic [7:0]  strb_base;
    logic [63:0] ld_data;

    assign size    = lsu_op[OP_SIZE_D:OP_SIZE_B];
    assign size_ok = is_onehot4(size);

    always_comb begin
        amask     = 3'd0;
        strb_base = 8'h00;
        unique case (size)
            4'b0001: begin amask = 3'd0; strb_base = STRB_B; end
            4'b0010: begin amask = 3'd1; strb_base = STRB_H; end
            4'b0100: begin amask = 3'd3; strb_base = STRB_W; end
            4'b1000: begin amask = 3'd7; strb_base = STRB_D; end
            default: begin amask = 3'd0; strb_base = 8'h00;  end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign fault  = !size_ok || ((addr[2:0] & amask) != 3'd0);
    assign off_al = addr[2:0];
`else
    // Round down to natural alignment; only a malformed size faults.
    assign fault  = !size_ok;
    assign off_al = addr[2:0] & ~amask;
`endif

    lsu_load_ext u_load_ext (
        .rdata (mem_rdata),
        .off   (off_q),
        .size  (size_q),
        .uns   (uns_q),
        .data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            req_ready     <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wstrb     <= 8'h00;
            mem_wdata     <= 64'd0;
            resp_valid    <= 1'b0;
            resp_data     <= 64'd0;
            resp_misalign <= 1'b0;
            off_q         <= 3'd0;
            size_q        <= 4'd0;
            uns_q         <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    off_q     <= off_al;
                    size_q    <= size;
                    uns_q     <= lsu_op[OP_UNS];
                    if (!lsu_op[OP_EN] || fault) begin
                        state         <= ST_DONE;
                        resp_valid    <= 1'b1;
                        resp_data     <= 64'd0;
                        resp_misalign <= lsu_op[OP_EN];
                    end else begin
                        state         <= ST_REQ;
                        mem_req_valid <= 1'b1;
                        mem_addr      <= {addr[ADDR_WIDTH-1:3], 3'b000};
                        mem_we        <= lsu_op[OP_WE];
                        mem_wstrb     <= lsu_op[OP_WE] ? (strb_base << off_al) : 8'h00;
                        mem_wdata     <= lsu_op[OP_WE] ? (wdata << {off_al, 3'b000}) : 64'd0;
                    end
                end
                ST_REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= ST_WAIT;
                end
                ST_WAIT: if (mem_resp_valid) begin
                    resp_valid    <= 1'b1;
                    resp_data     <= mem_we ? 64'd0 : ld_data;
                    resp_misalign <= 1'b0;
                    state         <= ST_DONE;
                end
                ST_DONE: begin
                    resp_valid    <= 1'b0;
                    resp_misalign <= 1'b0;
                    req_ready     <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_64i.sv
// Directed bench for lsu_64i: stores, signed/unsigned loads, faults, bus stalls
// and reset mid-transaction, with hand-computed expectations.
module tb_lsu_64i;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  lsu_op;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_misalign;

    int n_chk = 0;
    int n_err = 0;

    // captured per access
    logic [63:0] c_addr, c_wdata, c_rdat;
    logic [7:0]  c_strb;
    logic        c_we, c_mis, saw_req, stable, rv_after, rdy_after;
    int          rcyc;

    localparam logic [6:0] OP_SB  = 7'h62;
    localparam logic [6:0] OP_SH  = 7'h64;
    localparam logic [6:0] OP_SD  = 7'h70;
    localparam logic [6:0] OP_LB  = 7'h42;
    localparam logic [6:0] OP_LBU = 7'h43;
    localparam logic [6:0] OP_LH  = 7'h44;
    localparam logic [6:0] OP_LW  = 7'h48;
    localparam logic [6:0] OP_LWU = 7'h49;
    localparam logic [6:0] OP_LD  = 7'h50;
    localparam logic [6:0] OP_BAD = 7'h46;
    localparam logic [6:0] OP_NOP = 7'h20;

    always #5 clk = ~clk;

    lsu_64i #(.ADDR_WIDTH(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .lsu_op         (lsu_op),
        .addr           (addr),
        .wdata          (wdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wstrb      (mem_wstrb),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_misalign  (resp_misalign)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; cycle 0 is the accepting edge.
    task automatic access(input logic [6:0] op, input logic [63:0] a, input logic [63:0] wd,
                          input logic [63:0] rd, input int stall);
        int cyc, nst;
        logic hs;
        cyc = 0; nst = 0; hs = 1'b0;
        saw_req = 1'b0; stable = 1'b1; rcyc = 99;
        c_addr = '0; c_wdata = '0; c_strb = '0; c_we = 1'b0; c_mis = 1'b0; c_rdat = '0;
        req_valid = 1'b1; lsu_op = op; addr = a; wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (cyc < 30) begin
            mem_resp_valid = 1'b0;
            mem_req_ready  = 1'b0;
            if (resp_valid) begin
                rcyc = cyc; c_rdat = resp_data; c_mis = resp_misalign;
                break;
            end
            if (mem_req_valid) begin
                if (!saw_req) begin
                    saw_req = 1'b1;
                    c_addr = mem_addr; c_wdata = mem_wdata; c_strb = mem_wstrb; c_we = mem_we;
                end else if (mem_addr !== c_addr || mem_wdata !== c_wdata ||
                             mem_wstrb !== c_strb || mem_we !== c_we) begin
                    stable = 1'b0;
                end
                if (nst == stall) begin
                    mem_req_ready = 1'b1; hs = 1'b1;
                end else begin
                    nst++;
                end
            end else if (hs) begin
                mem_resp_valid = 1'b1; mem_rdata = rd; hs = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        @(negedge clk);
        rv_after  = resp_valid;
        rdy_after = req_ready;
    endtask

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; lsu_op = '0; addr = '0; wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_mem_wstrb", {56'd0, mem_wstrb}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);

        access(OP_SB, 64'h1003, 64'hAB, 64'd0, 0);
        chk("sb_addr", c_addr, 64'h1000);
        chk("sb_strb", {56'd0, c_strb}, 64'h08);
        chk("sb_wdata", c_wdata, 64'h00000000AB000000);
        chk("sb_we", {63'd0, c_we}, 64'd1);
        chk("sb_data", c_rdat, 64'd0);
        chk("sb_cycle", rcyc, 3);
        chk("sb_pulse_end", {63'd0, rv_after}, 64'd0);
        chk("sb_ready_back", {63'd0, rdy_after}, 64'd1);

        access(OP_SH, 64'h1006, 64'h1234, 64'd0, 0);
        chk("sh_strb", {56'd0, c_strb}, 64'hC0);
        chk("sh_wdata", c_wdata, 64'h1234000000000000);

        access(OP_LB, 64'h2005, 64'd0, 64'h0000800000000000, 0);
        chk("lb_data", c_rdat, 64'hFFFFFFFFFFFFFF80);
        chk("lb_we", {63'd0, c_we}, 64'd0);
        chk("lb_addr", c_addr, 64'h2000);
        access(OP_LBU, 64'h2005, 64'd0, 64'h0000800000000000, 0);
        chk("lbu_data", c_rdat, 64'h0000000000000080);

        access(OP_LW, 64'h3004, 64'd0, 64'h8765432100000000, 0);
        chk("lw_data", c_rdat, 64'hFFFFFFFF87654321);
        access(OP_LWU, 64'h3004, 64'd0, 64'h8765432100000000, 0);
        chk("lwu_data", c_rdat, 64'h0000000087654321);

        access(OP_LD, 64'h4004, 64'd0, 64'h1122334455667788, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("ld_mis_cycle", rcyc, 1);
        chk("ld_mis_flag", {63'd0, c_mis}, 64'd1);
        chk("ld_mis_nobus", {63'd0, saw_req}, 64'd0);
`else
        chk("ld_round_addr", c_addr, 64'h4000);
        chk("ld_round_data", c_rdat, 64'h1122334455667788);
        chk("ld_round_cycle", rcyc, 3);
        chk("ld_round_flag", {63'd0, c_mis}, 64'd0);
`endif

        access(OP_LH, 64'h7003, 64'd0, 64'h00000000ABCD1234, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_mis_flag", {63'd0, c_mis}, 64'd1);
`else
        chk("lh_round_data", c_rdat, 64'hFFFFFFFFFFFFABCD);
`endif

        access(OP_BAD, 64'h6000, 64'd0, 64'd0, 0);
        chk("bad_cycle", rcyc, 1);
        chk("bad_flag", {63'd0, c_mis}, 64'd1);
        chk("bad_nobus", {63'd0, saw_req}, 64'd0);

        access(OP_NOP, 64'h6001, 64'hFF, 64'd0, 0);
        chk("nop_cycle", rcyc, 1);
        chk("nop_flag", {63'd0, c_mis}, 64'd0);
        chk("nop_data", c_rdat, 64'd0);

        access(OP_SD, 64'h5000, 64'hDEADBEEFCAFEF00D, 64'd0, 3);
        chk("stall_stable", {63'd0, stable}, 64'd1);
        chk("stall_cycle", rcyc, 6);
        chk("stall_strb", {56'd0, c_strb}, 64'hFF);
        chk("stall_wdata", c_wdata, 64'hDEADBEEFCAFEF00D);

        // reset while waiting for the load response
        req_valid = 1'b1; lsu_op = OP_LD; addr = 64'h8000;
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rstw_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        mem_resp_valid = 1'b1; mem_rdata = 64'h55;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) seen++;
            @(negedge clk);
        end
        chk("rstw_no_resp", seen, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
